mem_arbiter: RTL and testbench

Shares the single data port of the memory model between the instruction-fetch requester (IF) and the load/store requester (LS). Arbitrates, latches the winning request, sequences the access over a configurable number of cycles and returns a registered response. Sits between the core's fetch/LSU and the memory model's mem_addr / mem_wdata / mem_byte_en / mem_read_req / mem_write_req / mem_rdata_raw pins.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arb_prio.sv | 50 +++++
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory port arbiter
// Contents: BAD_VAL (read data returned for rejected accesses), arb_state_t, arb_owner_t.
package mem_arbiter_pkg;

    localparam logic [31:0] BAD_VAL = 32'hBAD0_BAD0;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - winner select between IF and LS with IF anti-starvation counter
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   if_req_i, ls_req_i   requests from fetch and load/store
//   idle_i               arbiter is in IDLE; grants are only issued then
//   if_gnt_o, ls_gnt_o   combinational one-hot grant
module mem_arb_prio #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req_i,
    input  logic ls_req_i,
    input  logic idle_i,
    output logic if_gnt_o,
    output logic ls_gnt_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       force_if;

    always_comb begin
        force_if = if_req_i && ls_req_i && (starve_cnt_q >= LIMIT);
        ls_gnt_o = idle_i && ls_req_i && !force_if;
        if_gnt_o = idle_i && if_req_i && (!ls_req_i || force_if);
    end

    // Only IDLE cycles touch the counter, since grants never happen elsewhere.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (idle_i) begin
            if (if_gnt_o || !if_req_i) begin
                starve_cnt_d = 4'd0;
            end else if (ls_gnt_o && starve_cnt_q != 4'hF) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates IF and LS onto the single memory data port
// Ports: clk, rst_n; per requester req/we/addr/wdata/be in, gnt/rvalid/rdata/err out;
//        downstream mem_addr/mem_wdata/mem_byte_en/mem_read_req/mem_write_req out, mem_rdata_raw in.
// Optional: MEM_ARB_BOUNDS_CHECK_EN enables the out-of-range check (err/BAD_VAL, no downstream strobe).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_SIZE     = 8192,
    parameter int unsigned WAIT_CYCLES  = 0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic        if_we,
    input  logic [31:0] if_addr,
    input  logic [31:0] if_wdata,
    input  logic [3:0]  if_be,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    output logic        mem_read_req,
    output logic        mem_write_req,
    input  logic [31:0] mem_rdata_raw
);

    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [31:0] ADDR_MAX  = 32'(MEM_SIZE - 4);
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    arb_state_t  state_q, state_d;
    arb_owner_t  owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        bad_q, bad_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        in_idle, in_access, last_access, in_resp;
    logic        win_we;
    logic [31:0] win_addr, win_wdata;
    logic [3:0]  win_be;

    assign in_idle     = (state_q == IDLE);
    assign in_access   = (state_q == ACCESS);
    assign in_resp     = (state_q == RESP);
    assign last_access = in_access && (wait_cnt_q == WAIT_LAST);

    mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req_i (if_req),
        .ls_req_i (ls_req),
        .idle_i   (in_idle),
        .if_gnt_o (if_gnt),
        .ls_gnt_o (ls_gnt)
    );

    always_comb begin
        win_we    = ls_gnt ? ls_we    : if_we;
        win_addr  = ls_gnt ? ls_addr  : if_addr;
        win_wdata = ls_gnt ? ls_wdata : if_wdata;
        win_be    = ls_gnt ? ls_be    : if_be;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        bad_d      = bad_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (if_gnt || ls_gnt) begin
                    state_d    = ACCESS;
                    owner_d    = ls_gnt ? OWN_LS : OWN_IF;
                    we_d       = win_we;
                    addr_d     = win_addr;
                    wdata_d    = win_wdata;
                    be_d       = win_be;
                    bad_d      = BOUNDS_EN && (win_addr > ADDR_MAX);
                    wait_cnt_d = 4'd0;
                end
            end
            ACCESS: begin
                if (last_access) begin
                    state_d = RESP;
                    err_d   = bad_q;
                    if (bad_q) begin
                        rdata_d = BAD_VAL;
                    end else if (we_q) begin
                        rdata_d = 32'd0;
                    end else begin
                        rdata_d = mem_rdata_raw;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            bad_q      <= 1'b0;
            wait_cnt_q <= 4'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            bad_q      <= bad_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Write strobe only in the final ACCESS cycle so a write commits exactly once.
    always_comb begin
        mem_addr      = in_access ? addr_q  : 32'd0;
        mem_wdata     = in_access ? wdata_q : 32'd0;
        mem_byte_en   = in_access ? be_q    : 4'd0;
        mem_read_req  = in_access && !we_q && !bad_q;
        mem_write_req = last_access && we_q && !bad_q;
    end

    always_comb begin
        if_rvalid = in_resp && (owner_q == OWN_IF);
        ls_rvalid = in_resp && (owner_q == OWN_LS);
        if_rdata  = if_rvalid ? rdata_q : 32'd0;
        ls_rdata  = ls_rvalid ? rdata_q : 32'd0;
        if_err    = if_rvalid && err_q;
        ls_err    = ls_rvalid && err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a reference memory and arbitration model
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int WAIT  = 2;
    localparam int LIMIT = 4;
    localparam int MSIZE = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_we, ls_req, ls_we;
    logic [31:0] if_addr, if_wdata, ls_addr, ls_wdata;
    logic [3:0]  if_be, ls_be;
    logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
    logic [31:0] if_rdata, ls_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata_raw;
    logic [3:0]  mem_byte_en;
    logic        mem_read_req, mem_write_req;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mem     [0:MSIZE-1];
    logic [7:0] ref_mem [0:MSIZE-1];

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_SIZE(MSIZE), .WAIT_CYCLES(WAIT), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_we(if_we), .if_addr(if_addr), .if_wdata(if_wdata), .if_be(if_be),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .mem_rdata_raw(mem_rdata_raw)
    );

    function automatic logic [7:0] init_byte(input int i);
        if (i >= 'h100 && i <= 'h103) return 8'(8'h11 * (i - 'h100 + 1));
        if (i >= 'h200 && i <= 'h203) return 8'h00;
        return 8'(i * 37 + 5);
    endfunction

    // Memory model: combinational read, byte-enabled write at the clock edge.
    initial begin
        for (int i = 0; i < MSIZE; i++) mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (mem_write_req) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byte_en[b]) mem[(int'(mem_addr[12:0]) + b) % MSIZE] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        mem_rdata_raw = 32'd0;
        for (int b = 0; b < 4; b++)
            mem_rdata_raw[8*b +: 8] = mem[(int'(mem_addr[12:0]) + b) % MSIZE];
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = ref_mem[(int'(a[12:0]) + b) % MSIZE];
        return r;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = mem[(int'(a[12:0]) + b) % MSIZE];
        return r;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[(int'(a[12:0]) + b) % MSIZE] = d[8*b +: 8];
    endtask

    function automatic logic all_out_zero();
        return ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_rdata, ls_rdata, if_err, ls_err,
                 mem_addr, mem_wdata, mem_byte_en, mem_read_req, mem_write_req} === '0);
    endfunction

    // Issues one request and observes it through to its response.
    task automatic run_access(input bit ls, input bit we, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, output int gnt_wait, output int rv_lat,
                              output int nrd, output int nwr, output logic [31:0] rd,
                              output logic er, output int side_bad);
        gnt_wait = 0; rv_lat = 0; nrd = 0; nwr = 0; rd = 'x; er = 1'bx; side_bad = 0;
        @(posedge clk); #1;
        if (ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = d; ls_be = be;
        end else begin
            if_req = 1'b1; if_we = we; if_addr = a; if_wdata = d; if_be = be;
        end
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (ls ? ls_gnt : if_gnt) begin
                gnt_wait = i;
                break;
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0;
        if (gnt_wait == 0) return;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            if (mem_read_req) nrd++;
            if (mem_write_req) nwr++;
            if ((mem_read_req || mem_write_req) &&
                (mem_addr !== a || mem_byte_en !== be || (mem_write_req && mem_wdata !== d))) side_bad++;
            if (if_gnt || ls_gnt) side_bad++;
            if (ls ? if_rvalid : ls_rvalid) side_bad++;
            if (ls ? ls_rvalid : if_rvalid) begin
                rv_lat = j;
                rd = ls ? ls_rdata : if_rdata;
                er = ls ? ls_err : if_err;
                if ((ls ? {if_rdata, if_err} : {ls_rdata, ls_err}) !== '0) side_bad++;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (!all_out_zero()) $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (!all_out_zero()) $display("FAIL idle_outputs: got nonzero outputs, want all 0");
        else n_pass++;
    endtask

    task automatic test_ls_read();
        int gw, rl, nr, nw, sb; logic [31:0] rd; logic er;
        run_access(1'b1, 1'b0, 32'h100, $urandom, 4'hF, gw, rl, nr, nw, rd, er, sb);
        n_checks++;
        if (gw !== 1) $display("FAIL ls_read_gnt: got wait %0d, want 1", gw); else n_pass++;
        n_checks++;
        if (nr !== WAIT + 1 || nw !== 0) $display("FAIL ls_read_strobes: got rd %0d wr %0d, want rd %0d wr 0", nr, nw, WAIT + 1);
        else n_pass++;
        n_checks++;
        if (rl !== WAIT + 2) $display("FAIL ls_read_latency: got %0d, want %0d", rl, WAIT + 2); else n_pass++;
        n_checks++;
        if (rd !== 32'h44332211 || er !== 1'b0) $display("FAIL ls_read_data: got %h err %b, want 44332211 err 0", rd, er);
        else n_pass++;
        n_checks++;
        if (sb !== 0) $display("FAIL ls_read_side: got %0d side errors, want 0", sb); else n_pass++;
    endtask

    task automatic test_write_readback();
        int gw, rl, nr, nw, sb; logic [31:0] rd; logic er;
        run_access(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011, gw, rl, nr, nw, rd, er, sb);
        ref_write(32'h200, 32'hDEADBEEF, 4'b0011);
        n_checks++;
        if (nw !== 1 || nr !== 0) $display("FAIL write_strobes: got wr %0d rd %0d, want wr 1 rd 0", nw, nr); else n_pass++;
        n_checks++;
        if (rl !== WAIT + 2 || rd !== 32'd0 || sb !== 0)
            $display("FAIL write_resp: got lat %0d data %h side %0d, want lat %0d data 0 side 0", rl, rd, sb, WAIT + 2);
        else n_pass++;
        run_access(1'b1, 1'b0, 32'h200, 32'd0, 4'hF, gw, rl, nr, nw, rd, er, sb);
        n_checks++;
        if (rd !== 32'h0000BEEF) $display("FAIL write_readback: got %h, want 0000beef", rd); else n_pass++;
    endtask

    task automatic test_if_read_wait();
        int gw, rl, nr, nw, sb; logic [31:0] rd; logic er;
        run_access(1'b0, 1'b0, 32'h0, $urandom, 4'hF, gw, rl, nr, nw, rd, er, sb);
        n_checks++;
        if (gw !== 1 || nr !== WAIT + 1 || rl !== WAIT + 2)
            $display("FAIL if_read_timing: got gnt %0d rd %0d lat %0d, want 1 %0d %0d", gw, nr, rl, WAIT + 1, WAIT + 2);
        else n_pass++;
        n_checks++;
        if (rd !== ref_word(32'h0) || er !== 1'b0 || sb !== 0)
            $display("FAIL if_read_data: got %h err %b side %0d, want %h err 0 side 0", rd, er, sb, ref_word(32'h0));
        else n_pass++;
    endtask

    task automatic test_arbitration();
        int starve = 0;
        int got = 0;
        int prev = 0;
        bit exp_ls;
        @(posedge clk); #1;
        if_req = 1'b1; if_we = 1'b0; if_addr = 32'h500; if_be = 4'hF;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400; ls_be = 4'hF;
        for (int t = 0; t < 10 * (WAIT + 3) + 20 && got < 10; t++) begin
            @(negedge clk);
            if (if_gnt || ls_gnt) begin
                exp_ls = (starve < LIMIT);
                n_checks++;
                if ((ls_gnt !== exp_ls) || (if_gnt !== !exp_ls))
                    $display("FAIL arb_grant_%0d: got if %b ls %b, want ls %b", got, if_gnt, ls_gnt, exp_ls);
                else n_pass++;
                if (got > 0) begin
                    n_checks++;
                    if (t - prev !== WAIT + 3) $display("FAIL arb_spacing_%0d: got %0d, want %0d", got, t - prev, WAIT + 3);
                    else n_pass++;
                end
                starve = exp_ls ? starve + 1 : 0;
                prev = t;
                got++;
            end
        end
        n_checks++;
        if (got !== 10) $display("FAIL arb_count: got %0d grants, want 10", got); else n_pass++;
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0;
        repeat (WAIT + 4) @(posedge clk);
    endtask

    task automatic test_bounds();
        int gw, rl, nr, nw, sb; logic [31:0] rd; logic er;
        run_access(1'b1, 1'b0, 32'h1FFE, $urandom, 4'hF, gw, rl, nr, nw, rd, er, sb);
        n_checks++;
        if (rl !== WAIT + 2) $display("FAIL bounds_latency: got %0d, want %0d", rl, WAIT + 2); else n_pass++;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
        n_checks++;
        if (nr !== 0 || nw !== 0) $display("FAIL bounds_strobes: got rd %0d wr %0d, want 0 0", nr, nw); else n_pass++;
        n_checks++;
        if (rd !== BAD_VAL || er !== 1'b1) $display("FAIL bounds_resp: got %h err %b, want %h err 1", rd, er, BAD_VAL);
        else n_pass++;
`else
        n_checks++;
        if (nr !== WAIT + 1) $display("FAIL bounds_strobes: got rd %0d, want %0d", nr, WAIT + 1); else n_pass++;
        n_checks++;
        if (rd !== ref_word(32'h1FFE) || er !== 1'b0)
            $display("FAIL bounds_resp: got %h err %b, want %h err 0", rd, er, ref_word(32'h1FFE));
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_access();
        int gw = 0;
        int bad = 0;
        int rl, nr, nw, sb; logic [31:0] rd; logic er;
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300; ls_wdata = 32'hCAFEF00D; ls_be = 4'hF;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (ls_gnt) begin gw = i; break; end
        end
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gw == 0 || !all_out_zero()) $display("FAIL rst_async_outputs: got gnt wait %0d / nonzero outputs, want grant and all 0", gw);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < WAIT + 4; j++) begin
            @(negedge clk);
            if (if_rvalid || ls_rvalid || mem_read_req || mem_write_req) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL rst_no_resp: got %0d active cycles, want 0", bad); else n_pass++;
        n_checks++;
        if (model_word(32'h300) !== ref_word(32'h300))
            $display("FAIL rst_mem_unchanged: got %h, want %h", model_word(32'h300), ref_word(32'h300));
        else n_pass++;
        run_access(1'b1, 1'b0, 32'h300, 32'd0, 4'hF, gw, rl, nr, nw, rd, er, sb);
        n_checks++;
        if (gw !== 1 || rd !== ref_word(32'h300))
            $display("FAIL rst_regrant: got gnt %0d data %h, want 1 %h", gw, rd, ref_word(32'h300));
        else n_pass++;
    endtask

    task automatic test_random();
        int gw, rl, nr, nw, sb; logic [31:0] rd; logic er;
        bit ls, we; logic [31:0] a, d, exp; logic [3:0] be;
        for (int k = 0; k < 24; k++) begin
            ls = 1'($urandom); we = 1'($urandom);
            a  = {19'd0, 11'($urandom_range(0, 2047)), 2'b00};
            d  = $urandom; be = 4'($urandom);
            exp = we ? 32'd0 : ref_word(a);
            run_access(ls, we, a, d, be, gw, rl, nr, nw, rd, er, sb);
            if (we) ref_write(a, d, be);
            n_checks++;
            if (gw !== 1 || rl !== WAIT + 2 || nr !== (we ? 0 : WAIT + 1) || nw !== (we ? 1 : 0) || sb !== 0)
                $display("FAIL rand_%0d_timing: got gnt %0d lat %0d rd %0d wr %0d side %0d (we %b)", k, gw, rl, nr, nw, sb, we);
            else n_pass++;
            n_checks++;
            if (rd !== exp || er !== 1'b0) $display("FAIL rand_%0d_data: got %h err %b, want %h err 0", k, rd, er, exp);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < MSIZE; i++) ref_mem[i] = init_byte(i);
        rst_n = 1'b0;
        if_req = 1'b0; if_we = 1'b0; if_addr = 32'd0; if_wdata = 32'd0; if_be = 4'd0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_be = 4'd0;
        test_reset();
        test_ls_read();
        test_write_readback();
        test_if_read_wait();
        test_arbitration();
        test_bounds();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
